// File: rtl/sys_defs.sv
// Shared core definitions: datapath widths and the recovery sequencer state encoding.
// Exposed here so the debug tracer can decode RECOV_STATE without pulling in the controller.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB
`define ROB 5
`endif

package sys_defs;
   localparam int XLEN_W = `XLEN;
   localparam int ROB_W  = `ROB;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FLUSH      = 3'd1,
      DRAIN      = 3'd2,
      REDIRECT   = 3'd3,
      HALT_DRAIN = 3'd4,
      HALTED     = 3'd5
   } RECOV_STATE;
endpackage

// File: rtl/recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; count is registered, one cycle from en.
// No handshake: holds at all-ones while en stays high.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/recovery_ctrl.sv
// Recovery/halt sequencer: squash at T+1, fetch redirect at T+2+D (D = drain cycles >= 1).
// Requests outside IDLE are stale and dropped; dispatch is stalled for the whole sequence.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB
`define ROB 5
`endif

module recovery_ctrl
   import sys_defs::*;
#(
   parameter int DRAIN_TIMEOUT = 256,
   parameter int CNT_W         = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              recover_req,
   input  logic [`XLEN-1:0]  recover_pc,
   input  logic [`ROB-1:0]   recover_fl_head,
   input  logic              halt_req,
   input  logic              sq_busy,
   input  logic              mem_pending,
   output logic              squash,
   output logic              maptable_restore,
   output logic              fl_restore,
   output logic [`ROB-1:0]   fl_head_out,
   output logic              fetch_redirect,
   output logic [`XLEN-1:0]  redirect_pc,
   output logic              dispatch_stall,
   output logic              halted,
   output logic              busy,
   output logic              drain_err,
   output logic [CNT_W-1:0]  recover_cnt
);

   localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(DRAIN_TIMEOUT - 1);

   RECOV_STATE    state;
   logic [TW-1:0] drain_tmr;
   logic          accept;
   logic          drained;

   assign accept  = (state == IDLE) && !halt_req && recover_req;
   assign drained = !sq_busy && !mem_pending;

   sat_counter #(.W(CNT_W)) u_recover_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (1'b0),
      .en    (accept),
      .cnt   (recover_cnt)
   );

   // Cleared while in FLUSH so the first DRAIN cycle sees zero.
   sat_counter #(.W(TW)) u_drain_tmr (
      .clock (clock),
      .reset (reset),
      .clr   (state == FLUSH),
      .en    (state == DRAIN),
      .cnt   (drain_tmr)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         squash           <= 1'b0;
         maptable_restore <= 1'b0;
         fl_restore       <= 1'b0;
         fl_head_out      <= '0;
         fetch_redirect   <= 1'b0;
         redirect_pc      <= '0;
         dispatch_stall   <= 1'b0;
         halted           <= 1'b0;
         busy             <= 1'b0;
         drain_err        <= 1'b0;
      end else begin
         squash           <= 1'b0;
         maptable_restore <= 1'b0;
         fl_restore       <= 1'b0;
         fetch_redirect   <= 1'b0;
         case (state)
            IDLE: begin
               if (halt_req) begin
                  state          <= HALT_DRAIN;
                  dispatch_stall <= 1'b1;
                  busy           <= 1'b1;
               end else if (recover_req) begin
                  state            <= FLUSH;
                  redirect_pc      <= recover_pc;
                  fl_head_out      <= recover_fl_head;
                  squash           <= 1'b1;
                  maptable_restore <= 1'b1;
                  fl_restore       <= 1'b1;
                  dispatch_stall   <= 1'b1;
                  busy             <= 1'b1;
               end
            end
            FLUSH: begin
               state <= DRAIN;
            end
            DRAIN: begin
               // A clean drain wins over the timeout on the final cycle.
               if (drained) begin
                  state          <= REDIRECT;
                  fetch_redirect <= 1'b1;
               end else if (drain_tmr == TLAST) begin
                  state          <= REDIRECT;
                  fetch_redirect <= 1'b1;
                  drain_err      <= 1'b1;
               end
            end
            REDIRECT: begin
               state          <= IDLE;
               dispatch_stall <= 1'b0;
               busy           <= 1'b0;
            end
            HALT_DRAIN: begin
               if (!sq_busy) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
